keystream_gen: RTL and testbench
================================

KEYSTREAM_GEN -- requirements
Module: keystream_gen

Interface
REQ-001 The block SHALL have the parameter WARMUP_STEPS, default 16: the number of LFSR steps discarded after each seed load (range 1..255).
REQ-002 The block SHALL have the parameter DEFAULT_SEED, default 16'hACE1: the value substituted for an all-zero seed.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have the port seed_load, input, 1 bit: a one-cycle pulse that loads the seed.
REQ-006 The block SHALL have the port seed, input, 16 bits: the LFSR seed, sampled when seed_load=1.
REQ-007 The block SHALL have the port ks_valid, output, 1 bit: a keystream byte is available.
REQ-008 The block SHALL have the port ks_ready, input, 1 bit: the downstream XOR stage accepts the byte.
REQ-009 The block SHALL have the port ks_byte, output, 8 bits: the keystream byte, used as the XOR key operand.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while in WARMUP.

Function
REQ-011 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1: per step fb = s[15]^s[13]^s[12]^s[10], then s <= {s[14:0], fb}.
REQ-012 A seed_load with seed=16'h0000 SHALL load DEFAULT_SEED instead; any nonzero seed SHALL be loaded unchanged.
REQ-013 The LFSR SHALL advance at most one step per cycle, and only in WARMUP or in RUN while the buffer is not full.
REQ-014 Each byte SHALL be assembled from 8 consecutive fb bits, first bit in bit 7 (MSB first), and pushed into the buffer on the cycle its 8th bit is produced.
REQ-015 The FSM SHALL have the states IDLE, WARMUP and RUN.
- IDLE: after reset; no steps; ks_valid=0.
- seed_load in any state: next state WARMUP, step counter cleared, bit counter cleared, buffer flushed.
- WARMUP: after WARMUP_STEPS steps, next state RUN; these bits are never output.
- RUN: remains in RUN until reset or seed_load.
REQ-016 The output buffer SHALL be a 2-entry FIFO; ks_valid = buffer not empty; ks_byte = head entry, held stable while ks_valid=1 and ks_ready=0.
REQ-017 A transfer SHALL occur on a cycle where ks_valid=1 and ks_ready=1; the head entry is popped at that clock edge.
REQ-018 Push and pop in the same cycle on a full buffer SHALL be allowed and SHALL lose no data.
REQ-019 When the buffer is full and no pop occurs, bit generation SHALL stall: the LFSR and the partial byte are frozen and no bit is skipped.
REQ-020 On seed_load coincident with a transfer, the transfer SHALL complete and the buffer SHALL then be flushed; ks_valid=0 on the next cycle.
REQ-021 Steady-state throughput SHALL be one byte per 8 cycles; first ks_valid SHALL rise WARMUP_STEPS+8 cycles after the seed_load edge.
REQ-022 ks_ready SHALL be ignored while ks_valid=0.

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL set: state IDLE, LFSR 16'h0000, counters 0, buffer empty, ks_valid=0, ks_byte=8'h00, busy=0.
REQ-024 Reset SHALL take priority over seed_load; reset during WARMUP or RUN SHALL abort the operation with no residual output.

Structure
REQ-025 The shared package cipher_pkg SHALL hold LFSR_W=16, the tap mask 16'hB400, DEFAULT_SEED and the FSM state enum (ks_state_t).
REQ-026 The 2-entry buffer SHALL be the sub-module ks_fifo2 (8-bit data, push/pop/flush, full/empty); LFSR and FSM SHALL stay in keystream_gen.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset, then no seed_load for 50 cycles, ks_ready=1 -> ks_valid=0, ks_byte=8'h00, busy=0 throughout.
- seed_load with seed=16'hACE1, ks_ready=1 -> busy=1 for 16 cycles; first ks_valid on cycle 24; 32 bytes match a bit-accurate model.
- seed_load with seed=16'h0000 -> byte stream identical to the 16'hACE1 run.
- ks_ready=0 for 100 cycles after warmup -> exactly 2 bytes buffered, LFSR frozen; after ks_ready=1 the stream continues with no skipped or duplicated byte versus the model.
- seed_load with seed=16'h1234 coincident with a transfer in RUN -> that byte is consumed, ks_valid=0 next cycle, new stream matches the model for 16'h1234.
- rst_n=0 for one cycle mid-RUN with a full buffer -> ks_valid=0 next cycle, state IDLE, and no output until the next seed_load.

Source files
------------

// File: rtl/cipher_pkg.sv
// ---------------------------------------------------------------------------
// cipher_pkg
// Shared definitions for the keystream generator:
//   LFSR_W        - LFSR width
//   TAP_MASK      - feedback taps (bits 15,13,12,10 -> x^16+x^14+x^13+x^11+1)
//   DEFAULT_SEED  - value loaded in place of an all-zero seed
//   ks_state_t    - generator FSM states
//   lfsr_fb()     - feedback bit of one Fibonacci step
// ---------------------------------------------------------------------------
package cipher_pkg;

   localparam int          LFSR_W       = 16;
   localparam logic [15:0] TAP_MASK     = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } ks_state_t;

   // XOR of the tapped bits is the bit shifted in at s[0].
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return ^(s & TAP_MASK);
   endfunction

endpackage

// File: rtl/ks_fifo2.sv
// ---------------------------------------------------------------------------
// ks_fifo2
// Two-entry byte FIFO between the bit assembler and the XOR stage.
//   clk, rst_n  - clock, synchronous active-low reset
//   push, din   - write a byte (accepted when not full, or full with pop)
//   pop         - remove head entry (ignored when empty)
//   flush       - discard all entries; wins over push/pop
//   dout        - head entry
//   full, empty - occupancy flags
// ---------------------------------------------------------------------------
module ks_fifo2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   logic [7:0] ent0;   // head
   logic [7:0] ent1;   // second entry
   logic [1:0] count;
   logic       do_pop;
   logic       do_push;

   assign do_pop  = pop && (count != 2'd0);
   // Full + pop frees the head in the same edge, so the push still fits.
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ent0  <= 8'h00;
         ent1  <= 8'h00;
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) ent0 <= din;
               else               ent1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               ent0  <= ent1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; incoming byte lands behind the new head.
               if (count == 2'd1) begin
                  ent0 <= din;
               end else begin
                  ent0 <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = ent0;
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/keystream_gen.sv
// ---------------------------------------------------------------------------
// keystream_gen
// 16-bit Fibonacci LFSR keystream source. After a seed load the LFSR runs
// WARMUP_STEPS discarded steps, then packs feedback bits MSB-first into
// bytes which are queued in a 2-entry FIFO for a valid/ready consumer.
//   clk       - clock
//   rst_n     - synchronous active-low reset (priority over seed_load)
//   seed_load - one-cycle pulse: load seed, restart warmup, flush output
//   seed      - LFSR seed (0 selects DEFAULT_SEED)
//   ks_valid  - keystream byte available
//   ks_ready  - consumer accepts ks_byte
//   ks_byte   - keystream byte (FIFO head)
//   busy      - high during warmup
// ---------------------------------------------------------------------------
module keystream_gen
   import cipher_pkg::*;
#(
   parameter int          WARMUP_STEPS = 16,
   parameter logic [15:0] DEFAULT_SEED = cipher_pkg::DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        seed_load,
   input  logic [15:0] seed,
   output logic        ks_valid,
   input  logic        ks_ready,
   output logic [7:0]  ks_byte,
   output logic        busy
);

   localparam logic [7:0] LAST_STEP = 8'(WARMUP_STEPS - 1);

   ks_state_t         state;
   logic [LFSR_W-1:0] lfsr;
   logic [7:0]        step_cnt;
   logic [2:0]        bit_cnt;
   logic [6:0]        partial;   // first 7 bits of the byte being built
   logic              fb;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              adv;
   logic              push;
   logic [7:0]        push_byte;

   assign fb       = lfsr_fb(lfsr);
   assign ks_valid = !fifo_empty;
   assign pop      = ks_valid && ks_ready;

   // RUN advances only while the finished byte will have room; when the
   // FIFO is full and nothing pops, LFSR and partial byte freeze together.
   assign adv       = (state == ST_RUN) && (!fifo_full || pop) && !seed_load;
   assign push      = adv && (bit_cnt == 3'd7);
   assign push_byte = {partial, fb};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         lfsr     <= '0;
         step_cnt <= 8'd0;
         bit_cnt  <= 3'd0;
         partial  <= 7'd0;
         busy     <= 1'b0;
      end else if (seed_load) begin
         // Zero is the LFSR's lock-up state, so it is replaced.
         lfsr     <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
         state    <= ST_WARMUP;
         step_cnt <= 8'd0;
         bit_cnt  <= 3'd0;
         partial  <= 7'd0;
         busy     <= 1'b1;
      end else begin
         case (state)
            ST_WARMUP: begin
               lfsr     <= {lfsr[LFSR_W-2:0], fb};
               step_cnt <= step_cnt + 8'd1;
               if (step_cnt == LAST_STEP) begin
                  state <= ST_RUN;
                  busy  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (adv) begin
                  lfsr    <= {lfsr[LFSR_W-2:0], fb};
                  partial <= {partial[5:0], fb};
                  bit_cnt <= bit_cnt + 3'd1;   // wraps after the 8th bit
               end
            end
            default: ;
         endcase
      end
   end

   // seed_load drives flush: a coincident transfer still pops, then the
   // buffer is emptied on the same edge.
   ks_fifo2 u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (seed_load),
      .din   (push_byte),
      .dout  (ks_byte),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_keystream_gen.sv
module tb_keystream_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seed_load;
   logic [15:0] seed;
   logic        ks_valid;
   logic        ks_ready;
   logic [7:0]  ks_byte;
   logic        busy;

   int nerr = 0;
   int nchk = 0;

   logic [7:0] exp_b [0:63];
   logic [7:0] got   [0:63];
   int         got_n;

   always #5 clk = ~clk;

   keystream_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_load (seed_load),
      .seed      (seed),
      .ks_valid  (ks_valid),
      .ks_ready  (ks_ready),
      .ks_byte   (ks_byte),
      .busy      (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nchk++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference LFSR: fb = s15^s13^s12^s10 shifted in at bit 0.
   function automatic logic [15:0] mstep(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [15:0] state_after(input logic [15:0] s0, input int n);
      logic [15:0] s;
      s = (s0 == 16'h0000) ? 16'hACE1 : s0;
      for (int i = 0; i < n; i++) s = mstep(s);
      return s;
   endfunction

   task automatic fill_exp(input logic [15:0] s0);
      logic [15:0] s;
      logic [7:0]  b;
      s = state_after(s0, 16);
      for (int k = 0; k < 64; k++) begin
         b = 8'h00;
         for (int j = 0; j < 8; j++) begin
            s = mstep(s);
            b = {b[6:0], s[0]};
         end
         exp_b[k] = b;
      end
   endtask

   task automatic do_seed(input logic [15:0] s);
      seed_load = 1'b1;
      seed      = s;
      tick;
      seed_load = 1'b0;
   endtask

   // c = samples after the seed edge until ks_valid; busy_n = busy samples seen.
   task automatic wait_first(output int c, output int busy_n);
      c = 0;
      busy_n = 0;
      while (!ks_valid && c < 300) begin
         if (busy) busy_n++;
         tick;
         c++;
      end
   endtask

   task automatic collect(input int n, input bit chk_gap);
      int since   = 0;
      int bad_gap = 0;
      int budget  = 0;
      got_n = 0;
      while (got_n < n && budget < 2000) begin
         if (ks_valid && ks_ready) begin
            if (chk_gap && got_n > 0 && since != 8) bad_gap++;
            got[got_n] = ks_byte;
            got_n++;
            since = 0;
         end
         tick;
         since++;
         budget++;
      end
      chk("collect_count", got_n, n);
      if (chk_gap) chk("gap_8_cycles", bad_gap, 0);
   endtask

   task automatic cmp_bytes(input string tag, input int n, input int off);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s[%0d]", tag, i), got[i], exp_b[off+i]);
   endtask

   initial begin
      int c, bn, viol, guard;

      rst_n = 1'b0; seed_load = 1'b0; seed = 16'h0000; ks_ready = 1'b1;
      tick; tick;
      chk("rst_valid", ks_valid, 0);
      chk("rst_byte",  ks_byte, 8'h00);
      chk("rst_busy",  busy, 0);
      chk("rst_state", dut.state, cipher_pkg::ST_IDLE);
      chk("rst_lfsr",  dut.lfsr, 16'h0000);
      rst_n = 1'b1;

      // Idle without seed: nothing ever appears.
      viol = 0;
      repeat (50) begin
         tick;
         if (ks_valid !== 1'b0 || ks_byte !== 8'h00 || busy !== 1'b0) viol++;
      end
      chk("idle_quiet", viol, 0);

      // Seed ACE1: 16 busy cycles, first byte 24 cycles after the seed edge.
      fill_exp(16'hACE1);
      do_seed(16'hACE1);
      wait_first(c, bn);
      chk("ace1_busy_cycles", bn, 16);
      chk("ace1_first_valid", c, 24);
      collect(32, 1'b1);
      cmp_bytes("ace1_byte", 32, 0);

      // Zero seed substitutes ACE1: identical stream.
      do_seed(16'h0000);
      wait_first(c, bn);
      chk("zero_first_valid", c, 24);
      collect(32, 1'b1);
      cmp_bytes("zero_byte", 32, 0);

      // Backpressure: two bytes buffer, LFSR stalls after 16+16 steps.
      ks_ready = 1'b0;
      fill_exp(16'h5A5A);
      do_seed(16'h5A5A);
      repeat (116) tick;
      chk("bp_valid", ks_valid, 1);
      chk("bp_head", ks_byte, exp_b[0]);
      chk("bp_count", dut.u_fifo.count, 2);
      chk("bp_lfsr_frozen", dut.lfsr, state_after(16'h5A5A, 32));
      ks_ready = 1'b1;
      collect(8, 1'b0);
      cmp_bytes("bp_byte", 8, 0);

      // Seed load coincident with a transfer of byte 8.
      guard = 0;
      while (!ks_valid && guard < 50) begin tick; guard++; end
      chk("co_head", ks_byte, exp_b[8]);
      fill_exp(16'h1234);
      do_seed(16'h1234);
      chk("co_valid_dropped", ks_valid, 0);
      chk("co_busy", busy, 1);
      wait_first(c, bn);
      chk("co_first_valid", c, 24);
      collect(16, 1'b1);
      cmp_bytes("s1234_byte", 16, 0);

      // Reset mid-RUN with a full buffer.
      ks_ready = 1'b0;
      repeat (30) tick;
      chk("rr_full", dut.u_fifo.count, 2);
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("rr_valid", ks_valid, 0);
      chk("rr_byte", ks_byte, 8'h00);
      chk("rr_busy", busy, 0);
      chk("rr_state", dut.state, cipher_pkg::ST_IDLE);
      ks_ready = 1'b1;
      viol = 0;
      repeat (40) begin
         tick;
         if (ks_valid !== 1'b0 || busy !== 1'b0) viol++;
      end
      chk("rr_quiet", viol, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
